ace_snoop_responder: RTL

// - Cache-side end of the ACE snoop channels driven by ace_ccu.
// - Accepts one AC snoop at a time and performs a lookup and state update on the local dcache.
// - Returns CR (crresp) and, when DataTransfer is set, the full line on CD as DcacheLineWidth/AxiDataWidth beats.

---
 rtl/ace_snoop_responder_pkg.sv | 79 +++++++
 rtl/ace_snoop_responder_if.sv | 48 ++++
 rtl/ace_snoop_cd_serializer.sv | 62 ++++++
 rtl/ace_snoop_responder.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/ace_snoop_responder_pkg.sv
// Shared types, opcode constants and the snoop decode rules for the ACE snoop responder.
// Imported by the interface, the CD serializer and the responder top.
package ace_snoop_responder_pkg;

    typedef logic [3:0] arsnoop_t;
    typedef logic [4:0] crresp_t;

    localparam arsnoop_t SNP_READ_ONCE             = 4'b0000;
    localparam arsnoop_t SNP_READ_SHARED           = 4'b0001;
    localparam arsnoop_t SNP_READ_CLEAN            = 4'b0010;
    localparam arsnoop_t SNP_READ_NOT_SHARED_DIRTY = 4'b0011;
    localparam arsnoop_t SNP_READ_UNIQUE           = 4'b0111;
    localparam arsnoop_t SNP_CLEAN_SHARED          = 4'b1000;
    localparam arsnoop_t SNP_CLEAN_INVALID         = 4'b1001;
    localparam arsnoop_t SNP_MAKE_INVALID          = 4'b1101;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOOKUP   = 3'd1,
        S_WAIT_RSP = 3'd2,
        S_UPDATE   = 3'd3,
        S_SEND_CR  = 3'd4,
        S_SEND_CD  = 3'd5
    } snoop_resp_state_e;

    // resp bit order: {WasUnique, IsShared, PassDirty, Error, DataTransfer}
    typedef struct packed {
        crresp_t resp;
        logic    upd;
        logic    inval;
        logic    clean;
        logic    shared;
    } snoop_dec_t;

    function automatic snoop_dec_t snoop_decode(input arsnoop_t op, input logic hit,
                                                input logic dirty, input logic shared);
        snoop_dec_t d;
        logic dt, is, pd, err, upd, inval, clean, shr;
        dt = 1'b0; is = 1'b0; pd = 1'b0; err = 1'b0;
        upd = 1'b0; inval = 1'b0; clean = 1'b0; shr = 1'b0;
        case (op)
            SNP_READ_ONCE: begin
                dt = 1'b1; is = 1'b1;
            end
            SNP_READ_SHARED, SNP_READ_NOT_SHARED_DIRTY: begin
                dt = 1'b1; is = 1'b1; pd = dirty; upd = 1'b1; shr = 1'b1; clean = dirty;
            end
            SNP_READ_CLEAN: begin
                dt = 1'b1; is = 1'b1; upd = 1'b1; shr = 1'b1;
            end
            SNP_READ_UNIQUE: begin
                dt = 1'b1; pd = dirty; upd = 1'b1; inval = 1'b1;
            end
            SNP_CLEAN_INVALID: begin
                dt = dirty; pd = dirty; upd = 1'b1; inval = 1'b1;
            end
            SNP_CLEAN_SHARED: begin
                dt = dirty; pd = dirty; is = 1'b1; upd = 1'b1; clean = dirty; shr = 1'b1;
            end
            SNP_MAKE_INVALID: begin
                upd = 1'b1; inval = 1'b1;
            end
            default: begin
                err = 1'b1;
            end
        endcase
        // Unknown opcodes report Error whether or not the line is present
        if (err) begin
            d = '{resp: 5'b00010, upd: 1'b0, inval: 1'b0, clean: 1'b0, shared: 1'b0};
        end else if (!hit) begin
            d = '{resp: 5'b00000, upd: 1'b0, inval: 1'b0, clean: 1'b0, shared: 1'b0};
        end else begin
            d = '{resp: {!shared, is, pd, 1'b0, dt}, upd: upd, inval: inval,
                  clean: clean, shared: shr};
        end
        return d;
    endfunction

endpackage

// File: rtl/ace_snoop_responder_if.sv
// AC/CR/CD snoop channels plus the dcache lookup/update side-band of the snoop responder.
// slave = responder view, master = CCU/dcache view.
interface ace_snoop_responder_if #(
    parameter int AxiAddrWidth    = 64,
    parameter int AxiDataWidth    = 64,
    parameter int DcacheLineWidth = 128
);
    logic                                  ac_valid_i;
    logic                                  ac_ready_o;
    logic [AxiAddrWidth-1:0]               ac_addr_i;
    ace_snoop_responder_pkg::arsnoop_t     ac_snoop_i;
    logic                                  cr_valid_o;
    logic                                  cr_ready_i;
    ace_snoop_responder_pkg::crresp_t      cr_resp_o;
    logic                                  cd_valid_o;
    logic                                  cd_ready_i;
    logic [AxiDataWidth-1:0]               cd_data_o;
    logic                                  cd_last_o;
    logic                                  lkp_req_o;
    logic                                  lkp_gnt_i;
    logic [AxiAddrWidth-1:0]               lkp_addr_o;
    logic                                  lkp_valid_i;
    logic                                  lkp_hit_i;
    logic                                  lkp_dirty_i;
    logic                                  lkp_shared_i;
    logic [DcacheLineWidth-1:0]            lkp_data_i;
    logic                                  upd_valid_o;
    logic                                  upd_ready_i;
    logic                                  upd_inval_o;
    logic                                  upd_clean_o;
    logic                                  upd_shared_o;

    modport slave (
        input  ac_valid_i, ac_addr_i, ac_snoop_i, cr_ready_i, cd_ready_i,
               lkp_gnt_i, lkp_valid_i, lkp_hit_i, lkp_dirty_i, lkp_shared_i, lkp_data_i,
               upd_ready_i,
        output ac_ready_o, cr_valid_o, cr_resp_o, cd_valid_o, cd_data_o, cd_last_o,
               lkp_req_o, lkp_addr_o, upd_valid_o, upd_inval_o, upd_clean_o, upd_shared_o
    );

    modport master (
        output ac_valid_i, ac_addr_i, ac_snoop_i, cr_ready_i, cd_ready_i,
               lkp_gnt_i, lkp_valid_i, lkp_hit_i, lkp_dirty_i, lkp_shared_i, lkp_data_i,
               upd_ready_i,
        input  ac_ready_o, cr_valid_o, cr_resp_o, cd_valid_o, cd_data_o, cd_last_o,
               lkp_req_o, lkp_addr_o, upd_valid_o, upd_inval_o, upd_clean_o, upd_shared_o
    );
endinterface

// File: rtl/ace_snoop_cd_serializer.sv
// Holds one cache line and emits it on CD as LW/DW beats, lowest beat first, with last.
// Beats are offered only while en_i is high; done_o pulses on the final beat handshake.
module ace_snoop_cd_serializer #(
    parameter int AxiDataWidth    = 64,
    parameter int DcacheLineWidth = 128
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       load_i,
    input  logic [DcacheLineWidth-1:0] line_i,
    input  logic                       dt_i,
    input  logic                       en_i,
    input  logic                       cd_ready_i,
    output logic                       cd_valid_o,
    output logic [AxiDataWidth-1:0]    cd_data_o,
    output logic                       cd_last_o,
    output logic                       pending_o,
    output logic                       done_o
);
    localparam int NB = DcacheLineWidth / AxiDataWidth;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    logic [DcacheLineWidth-1:0] line_r;
    logic [CW-1:0]              cnt_r;
    logic                       pending_r;
    logic                       hs_s;
    logic                       last_s;

    assign last_s     = (cnt_r == CW'(NB - 1));
    assign cd_valid_o = en_i & pending_r;
    assign hs_s       = cd_valid_o & cd_ready_i;
    assign cd_data_o  = line_r[AxiDataWidth-1:0];
    assign cd_last_o  = cd_valid_o & last_s;
    assign pending_o  = pending_r;
    assign done_o     = hs_s & last_s;

    // Line shift register and beat counter; the current beat always sits in the low word
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            line_r    <= '0;
            cnt_r     <= '0;
            pending_r <= 1'b0;
        end else if (load_i) begin
            line_r    <= line_i;
            cnt_r     <= '0;
            pending_r <= dt_i;
        end else if (hs_s) begin
            line_r <= line_r >> AxiDataWidth;
            if (last_s) begin
                cnt_r     <= '0;
                pending_r <= 1'b0;
            end else begin
                cnt_r     <= cnt_r + CW'(1);
                pending_r <= 1'b1;
            end
        end else begin
            line_r    <= line_r;
            cnt_r     <= cnt_r;
            pending_r <= pending_r;
        end
    end
endmodule

// File: rtl/ace_snoop_responder.sv
// Cache-side ACE snoop responder: AC accept, dcache lookup, state update, CR, then CD line beats.
// Optional ACE_SNOOP_RESP_OVERLAP_EN lets CD beats run concurrently with the pending CR.
module ace_snoop_responder
    import ace_snoop_responder_pkg::*;
#(
    parameter int AxiAddrWidth    = 64,
    parameter int AxiDataWidth    = 64,
    parameter int DcacheLineWidth = 128
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    ace_snoop_responder_if.slave  bus
);
    localparam int OFF = $clog2(DcacheLineWidth / 8);

    snoop_resp_state_e        state_r, state_s;
    logic [AxiAddrWidth-1:0]  addr_r;
    arsnoop_t                 snoop_r;
    crresp_t                  resp_r;
    logic                     dt_r, upd_inval_r, upd_clean_r, upd_shared_r;
    logic                     ac_ready_r, lkp_req_r, upd_valid_r, cr_valid_r, cd_en_r, cr_done_r;
    logic                     ac_hs_s, gnt_hs_s, rsp_s, upd_hs_s, cr_hs_s, cr_fin_s;
    logic                     cd_pending_s, cd_done_s, cd_fin_s;
    snoop_dec_t               dec_s;

    assign ac_hs_s  = ac_ready_r & bus.ac_valid_i;
    assign gnt_hs_s = lkp_req_r & bus.lkp_gnt_i;
    assign rsp_s    = (state_r == S_WAIT_RSP) & bus.lkp_valid_i;
    assign upd_hs_s = upd_valid_r & bus.upd_ready_i;
    assign cr_hs_s  = cr_valid_r & bus.cr_ready_i;
    assign cr_fin_s = cr_done_r | cr_hs_s;
    assign cd_fin_s = !dt_r | !cd_pending_s | cd_done_s;
    assign dec_s    = snoop_decode(snoop_r, bus.lkp_hit_i, bus.lkp_dirty_i, bus.lkp_shared_i);

    assign bus.ac_ready_o   = ac_ready_r;
    assign bus.lkp_req_o    = lkp_req_r;
    assign bus.lkp_addr_o   = addr_r;
    assign bus.upd_valid_o  = upd_valid_r;
    assign bus.upd_inval_o  = upd_inval_r;
    assign bus.upd_clean_o  = upd_clean_r;
    assign bus.upd_shared_o = upd_shared_r;
    assign bus.cr_valid_o   = cr_valid_r;
    assign bus.cr_resp_o    = resp_r;

    // Next-state decode for the snoop sequence
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (ac_hs_s) state_s = S_LOOKUP;
                else         state_s = S_IDLE;
            end
            S_LOOKUP: begin
                if (gnt_hs_s) state_s = S_WAIT_RSP;
                else          state_s = S_LOOKUP;
            end
            S_WAIT_RSP: begin
                if (bus.lkp_valid_i) state_s = dec_s.upd ? S_UPDATE : S_SEND_CR;
                else                 state_s = S_WAIT_RSP;
            end
            S_UPDATE: begin
                if (upd_hs_s) state_s = S_SEND_CR;
                else          state_s = S_UPDATE;
            end
            S_SEND_CR: begin
`ifdef ACE_SNOOP_RESP_OVERLAP_EN
                if (cr_fin_s) state_s = cd_fin_s ? S_IDLE : S_SEND_CD;
                else          state_s = S_SEND_CR;
`else
                if (cr_hs_s) state_s = dt_r ? S_SEND_CD : S_IDLE;
                else         state_s = S_SEND_CR;
`endif
            end
            S_SEND_CD: begin
                if (cd_done_s) state_s = S_IDLE;
                else           state_s = S_SEND_CD;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State register and handshake outputs, registered from the next state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r     <= S_IDLE;
            ac_ready_r  <= 1'b0;
            lkp_req_r   <= 1'b0;
            upd_valid_r <= 1'b0;
            cr_valid_r  <= 1'b0;
            cr_done_r   <= 1'b0;
            cd_en_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            ac_ready_r  <= (state_s == S_IDLE);
            lkp_req_r   <= (state_s == S_LOOKUP);
            upd_valid_r <= (state_s == S_UPDATE);
            cr_valid_r  <= (state_s == S_SEND_CR) & !cr_fin_s;
            cr_done_r   <= (state_s == S_SEND_CR) & cr_fin_s;
`ifdef ACE_SNOOP_RESP_OVERLAP_EN
            cd_en_r     <= (state_s == S_SEND_CR) | (state_s == S_SEND_CD);
`else
            cd_en_r     <= (state_s == S_SEND_CD);
`endif
        end
    end

    // Captured snoop request and lookup-derived response/update
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_r       <= '0;
            snoop_r      <= 4'b0000;
            resp_r       <= 5'b00000;
            dt_r         <= 1'b0;
            upd_inval_r  <= 1'b0;
            upd_clean_r  <= 1'b0;
            upd_shared_r <= 1'b0;
        end else if (ac_hs_s) begin
            addr_r  <= {bus.ac_addr_i[AxiAddrWidth-1:OFF], {OFF{1'b0}}};
            snoop_r <= bus.ac_snoop_i;
        end else if (rsp_s) begin
            resp_r       <= dec_s.resp;
            dt_r         <= dec_s.resp[0];
            upd_inval_r  <= dec_s.inval;
            upd_clean_r  <= dec_s.clean;
            upd_shared_r <= dec_s.shared;
        end else begin
            addr_r       <= addr_r;
            snoop_r      <= snoop_r;
            resp_r       <= resp_r;
            dt_r         <= dt_r;
            upd_inval_r  <= upd_inval_r;
            upd_clean_r  <= upd_clean_r;
            upd_shared_r <= upd_shared_r;
        end
    end

    ace_snoop_cd_serializer #(
        .AxiDataWidth    (AxiDataWidth),
        .DcacheLineWidth (DcacheLineWidth)
    ) u_cd_ser (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (rsp_s),
        .line_i     (bus.lkp_data_i),
        .dt_i       (dec_s.resp[0]),
        .en_i       (cd_en_r),
        .cd_ready_i (bus.cd_ready_i),
        .cd_valid_o (bus.cd_valid_o),
        .cd_data_o  (bus.cd_data_o),
        .cd_last_o  (bus.cd_last_o),
        .pending_o  (cd_pending_s),
        .done_o     (cd_done_s)
    );
endmodule
